ifm: RTL and testbench

IFM -- requirements
Module: ifm

---
 rtl/ecap5_dproc_pkg.sv | 20 ++
 rtl/ifm.sv | 177 +++++++++++++++++
 tb/tb_ifm.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ecap5_dproc_pkg.sv
// Shared front-end constants: default boot address, Wishbone word select, word-align helper.
// Latency: none (constants and a pure function only).
// Backpressure: not applicable.
//
// Contents:
//   BOOT_ADDRESS  default first fetch address after reset
//   WB_SEL_WORD   byte-select value for full 32-bit word transfers
//   word_align()  forces the two low address bits to zero
package ecap5_dproc_pkg;

    localparam logic [31:0] BOOT_ADDRESS = 32'h0000_0000;
    localparam logic [3:0]  WB_SEL_WORD  = 4'hF;

    // Masking keeps every bit of the argument in use, so callers can pass
    // a full 32-bit bus without leaving the low bits dangling.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/ifm.sv
// Instruction fetch: reads words over pipelined Wishbone and presents them to decode.
// Latency: output_valid_o rises the cycle after wb_ack_i; 3 cycles per word (2 with prefetch).
// Backpressure: valid/ready to decode; holds instr_o/pc_o stable while !output_ready_i.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   branch_i, branch_target_i    one-cycle redirect from execute
//   output_valid_o/ready_i       handshake to decode; instr_o/pc_o carry the word and its address
//   wb_*                         Wishbone pipelined master, read-only (we=0, sel=F, dat_o=0)
//
// Optional feature: define IFM_PREFETCH_EN to add a one-entry buffer so the next
// fetch can start while decode still holds the previous word.
module ifm
    import ecap5_dproc_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = BOOT_ADDRESS
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        branch_i,
    input  logic [31:0] branch_target_i,

    input  logic        output_ready_i,
    output logic        output_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,

    output logic [31:0] wb_adr_o,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    input  logic        wb_stall_i
);

    typedef enum logic [1:0] {
        S_REQUEST  = 2'd0,
        S_WAIT_ACK = 2'd1,
        S_HOLD     = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    // Set when a redirect happens while a read is outstanding; the matching
    // ack is swallowed instead of being delivered to decode.
    logic        drop;
    logic        out_hs;

`ifdef IFM_PREFETCH_EN
    logic        buf_vld;
    logic [31:0] buf_instr;
    logic [31:0] buf_pc;
`endif

    assign out_hs = output_valid_o & output_ready_i;

    // Bus strobes are a decode of the state register. Gating with rst_i drops
    // the cycle in the very cycle reset is asserted rather than one later.
    assign wb_cyc_o = ~rst_i & (state != S_HOLD);
    assign wb_stb_o = ~rst_i & (state == S_REQUEST);
    assign wb_adr_o = pc;
    assign wb_we_o  = 1'b0;
    assign wb_sel_o = WB_SEL_WORD;
    assign wb_dat_o = '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= S_REQUEST;
            pc             <= word_align(RESET_ADDR);
            drop           <= 1'b0;
            output_valid_o <= 1'b0;
            instr_o        <= '0;
            pc_o           <= '0;
`ifdef IFM_PREFETCH_EN
            buf_vld        <= 1'b0;
            buf_instr      <= '0;
            buf_pc         <= '0;
`endif
        end else if (branch_i) begin
            // Redirect wins over everything else this cycle. A handshake that
            // completes now is simply consumed; nothing is replayed.
            pc             <= word_align(branch_target_i);
            output_valid_o <= 1'b0;
`ifdef IFM_PREFETCH_EN
            buf_vld        <= 1'b0;
`endif
            case (state)
                S_REQUEST: begin
                    if (!wb_stall_i) begin
                        // Old-address request got accepted: its response is
                        // still coming and must be discarded.
                        state <= S_WAIT_ACK;
                        drop  <= 1'b1;
                    end
                end
                S_WAIT_ACK: begin
                    if (wb_ack_i) begin
                        state <= S_REQUEST;
                        drop  <= 1'b0;
                    end else begin
                        drop  <= 1'b1;
                    end
                end
                S_HOLD: begin
                    state <= S_REQUEST;
                end
                default: begin
                    state <= S_REQUEST;
                end
            endcase
        end else begin
            // Default: an accepted word leaves the output register. Any load
            // below overrides this.
            if (out_hs) begin
                output_valid_o <= 1'b0;
            end

            case (state)
                S_REQUEST: begin
                    if (!wb_stall_i) begin
                        state <= S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    if (wb_ack_i) begin
                        if (drop) begin
                            drop  <= 1'b0;
                            state <= S_REQUEST;
                        end else begin
                            pc <= pc + 32'd4;
`ifdef IFM_PREFETCH_EN
                            if (!output_valid_o || output_ready_i) begin
                                output_valid_o <= 1'b1;
                                instr_o        <= wb_dat_i;
                                pc_o           <= pc;
                                state          <= S_REQUEST;
                            end else begin
                                // Decode is stalled on the current word: park
                                // this one and stop fetching until it drains.
                                buf_vld   <= 1'b1;
                                buf_instr <= wb_dat_i;
                                buf_pc    <= pc;
                                state     <= S_HOLD;
                            end
`else
                            output_valid_o <= 1'b1;
                            instr_o        <= wb_dat_i;
                            pc_o           <= pc;
                            state          <= S_HOLD;
`endif
                        end
                    end
                end
                S_HOLD: begin
                    if (out_hs) begin
`ifdef IFM_PREFETCH_EN
                        // Buffered word moves straight into the output register.
                        output_valid_o <= buf_vld;
                        instr_o        <= buf_instr;
                        pc_o           <= buf_pc;
                        buf_vld        <= 1'b0;
`endif
                        state <= S_REQUEST;
                    end
                end
                default: begin
                    state <= S_REQUEST;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifm.sv
// Directed bench for ifm: fetch sequence, decode backpressure, bus stall,
// redirects in each state, reset mid-transaction and pc wrap-around.
module tb_ifm;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        branch_i;
    logic [31:0] branch_target_i;
    logic        output_ready_i;
    logic        output_valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i;
    logic        wb_stall_i;
    logic        ack_en;

    // second instance: wrap-around start address, free-running
    logic        w_valid;
    logic [31:0] w_instr, w_pc, w_adr, w_dat_i, w_dat_o;
    logic        w_we, w_cyc, w_stb, w_ack;
    logic [3:0]  w_sel;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_F00D;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    ifm #(.RESET_ADDR(32'h0000_0100)) u_dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .branch_i        (branch_i),
        .branch_target_i (branch_target_i),
        .output_ready_i  (output_ready_i),
        .output_valid_o  (output_valid_o),
        .instr_o         (instr_o),
        .pc_o            (pc_o),
        .wb_adr_o        (wb_adr_o),
        .wb_dat_i        (wb_dat_i),
        .wb_dat_o        (wb_dat_o),
        .wb_we_o         (wb_we_o),
        .wb_sel_o        (wb_sel_o),
        .wb_cyc_o        (wb_cyc_o),
        .wb_stb_o        (wb_stb_o),
        .wb_ack_i        (wb_ack_i),
        .wb_stall_i      (wb_stall_i)
    );

    ifm #(.RESET_ADDR(32'hFFFF_FFF8)) u_wrap (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .branch_i        (1'b0),
        .branch_target_i (32'h0),
        .output_ready_i  (1'b1),
        .output_valid_o  (w_valid),
        .instr_o         (w_instr),
        .pc_o            (w_pc),
        .wb_adr_o        (w_adr),
        .wb_dat_i        (w_dat_i),
        .wb_dat_o        (w_dat_o),
        .wb_we_o         (w_we),
        .wb_sel_o        (w_sel),
        .wb_cyc_o        (w_cyc),
        .wb_stb_o        (w_stb),
        .wb_ack_i        (w_ack),
        .wb_stall_i      (1'b0)
    );

    // Zero-wait pipelined memory: ack the cycle after acceptance (gated by
    // ack_en). Deliberately not reset, so a stale ack can follow a DUT reset.
    logic        pend = 1'b0;
    logic [31:0] pend_adr = 32'h0;
    int          acc_count = 0;

    always @(posedge clk_i) begin
        if (wb_cyc_o && wb_stb_o && !wb_stall_i) begin
            pend      <= 1'b1;
            pend_adr  <= wb_adr_o;
            acc_count <= acc_count + 1;
        end else if (wb_ack_i) begin
            pend <= 1'b0;
        end
    end
    assign wb_ack_i = pend && ack_en;
    assign wb_dat_i = pend ? memf(pend_adr) : 32'h0;

    logic        w_pend = 1'b0;
    logic [31:0] w_pend_adr = 32'h0;
    always @(posedge clk_i) begin
        if (w_cyc && w_stb) begin
            w_pend     <= 1'b1;
            w_pend_adr <= w_adr;
        end else if (w_ack) begin
            w_pend <= 1'b0;
        end
    end
    assign w_ack   = w_pend;
    assign w_dat_i = w_pend ? memf(w_pend_adr) : 32'h0;

    logic [31:0] w_pc_log [3];
    logic [31:0] w_in_log [3];
    int          w_cnt = 0;
    always @(negedge clk_i) begin
        if (!rst_i && w_valid && w_cnt < 3) begin
            w_pc_log[w_cnt] <= w_pc;
            w_in_log[w_cnt] <= w_instr;
            w_cnt           <= w_cnt + 1;
        end
    end

    // Advance to the next negedge showing output_valid_o; n = negedges waited.
    task automatic wait_valid(input string tag, output int n);
        n = 0;
        @(negedge clk_i);
        n = 1;
        while (!output_valid_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        chk({tag, "_timeout"}, {31'd0, output_valid_o}, 32'd1);
    endtask

    initial begin
        int n;
        int acc0;
        rst_i           = 1'b1;
        branch_i        = 1'b0;
        branch_target_i = 32'h0;
        output_ready_i  = 1'b1;
        wb_stall_i      = 1'b0;
        ack_en          = 1'b1;

        repeat (3) @(negedge clk_i);
        chk("rst_valid",  {31'd0, output_valid_o}, 32'd0);
        chk("rst_cycstb", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
        chk("rst_instr",  instr_o, 32'h0);
        chk("rst_pc_o",   pc_o, 32'h0);
        chk("tie_we_sel", {27'd0, wb_we_o, wb_sel_o}, 32'h0000_000F);
        chk("tie_dat_o",  wb_dat_o, 32'h0);

        rst_i = 1'b0;
        #1;
        chk("first_req", {30'd0, wb_cyc_o, wb_stb_o}, 32'd3);
        chk("first_adr", wb_adr_o, 32'h0000_0100);

`ifdef IFM_PREFETCH_EN
        wait_valid("pf0", n);
        chk("pf0_lat", n, 2); chk("pf0_pc", pc_o, 32'h100); chk("pf0_in", instr_o, memf(32'h100));
        wait_valid("pf1", n);
        chk("pf1_lat", n, 2); chk("pf1_pc", pc_o, 32'h104); chk("pf1_in", instr_o, memf(32'h104));
        wait_valid("pf2", n);
        chk("pf2_lat", n, 2); chk("pf2_pc", pc_o, 32'h108);

        output_ready_i = 1'b0;
        acc0 = acc_count;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("pf_hold_pc", pc_o, 32'h108);
            chk("pf_hold_vld", {31'd0, output_valid_o}, 32'd1);
        end
        chk("pf_one_fetch", acc_count, acc0 + 1);
        output_ready_i = 1'b1;
        wait_valid("pf_buf", n);
        chk("pf_buf_lat", n, 1); chk("pf_buf_pc", pc_o, 32'h10C); chk("pf_buf_in", instr_o, memf(32'h10C));
        wait_valid("pf_next", n);
        chk("pf_next_lat", n, 2); chk("pf_next_pc", pc_o, 32'h110); chk("pf_next_in", instr_o, memf(32'h110));
`else
        // sequential fetch, one word per 3 cycles
        wait_valid("seq0", n);
        chk("seq0_lat", n, 2); chk("seq0_pc", pc_o, 32'h100); chk("seq0_in", instr_o, memf(32'h100));
        wait_valid("seq1", n);
        chk("seq1_lat", n, 3); chk("seq1_pc", pc_o, 32'h104); chk("seq1_in", instr_o, memf(32'h104));
        wait_valid("seq2", n);
        chk("seq2_lat", n, 3); chk("seq2_pc", pc_o, 32'h108); chk("seq2_in", instr_o, memf(32'h108));

        // decode backpressure
        output_ready_i = 1'b0;
        acc0 = acc_count;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("hold_pc",  pc_o, 32'h108);
            chk("hold_in",  instr_o, memf(32'h108));
            chk("hold_vld", {31'd0, output_valid_o}, 32'd1);
            chk("hold_stb", {31'd0, wb_stb_o}, 32'd0);
        end
        chk("hold_no_req", acc_count, acc0);
        output_ready_i = 1'b1;
        wait_valid("after_hold", n);
        chk("after_hold_lat", n, 3); chk("after_hold_pc", pc_o, 32'h10C);

        // bus stall
        wb_stall_i = 1'b1;
        acc0 = acc_count;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("stall_stb", {31'd0, wb_stb_o}, 32'd1);
            chk("stall_adr", wb_adr_o, 32'h110);
        end
        wb_stall_i = 1'b0;
        wait_valid("stall_done", n);
        chk("stall_lat", n, 2); chk("stall_pc", pc_o, 32'h110); chk("stall_in", instr_o, memf(32'h110));
        chk("stall_single", acc_count, acc0 + 1);

        // redirect in WAIT_ACK on the ack cycle
        @(negedge clk_i);
        chk("wa_req_adr", wb_adr_o, 32'h114);
        @(negedge clk_i);
        chk("wa_state", {30'd0, wb_stb_o, wb_ack_i}, 32'd1);
        branch_i = 1'b1; branch_target_i = 32'h2003;
        @(negedge clk_i);
        branch_i = 1'b0;
        chk("wa_br_vld", {31'd0, output_valid_o}, 32'd0);
        chk("wa_br_stb", {31'd0, wb_stb_o}, 32'd1);
        chk("wa_br_adr", wb_adr_o, 32'h2000);
        wait_valid("wa_tgt", n);
        chk("wa_tgt_lat", n, 2); chk("wa_tgt_pc", pc_o, 32'h2000); chk("wa_tgt_in", instr_o, memf(32'h2000));

        // redirects while stalled in REQUEST, back to back
        wb_stall_i = 1'b1;
        acc0 = acc_count;
        @(negedge clk_i);
        chk("rs_adr0", wb_adr_o, 32'h2004);
        branch_i = 1'b1; branch_target_i = 32'h3000;
        @(negedge clk_i);
        chk("rs_adr1", wb_adr_o, 32'h3000);
        chk("rs_stb1", {31'd0, wb_stb_o}, 32'd1);
        branch_target_i = 32'h4009;
        @(negedge clk_i);
        chk("rs_last_wins", wb_adr_o, 32'h4008);
        branch_i = 1'b0; wb_stall_i = 1'b0;
        wait_valid("rs_tgt", n);
        chk("rs_tgt_lat", n, 2); chk("rs_tgt_pc", pc_o, 32'h4008);
        chk("rs_single", acc_count, acc0 + 1);

        // redirect in HOLD together with a completing handshake
        branch_i = 1'b1; branch_target_i = 32'h5000;
        @(negedge clk_i);
        branch_i = 1'b0;
        chk("hb_vld", {31'd0, output_valid_o}, 32'd0);
        chk("hb_adr", wb_adr_o, 32'h5000);
        wait_valid("hb_tgt", n);
        chk("hb_tgt_lat", n, 2); chk("hb_tgt_pc", pc_o, 32'h5000);
        wait_valid("hb_next", n);
        chk("hb_next_lat", n, 3); chk("hb_next_pc", pc_o, 32'h5004);

        // reset while a read is outstanding; its ack arrives after reset
        ack_en = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("mr_wait", {30'd0, wb_cyc_o, wb_stb_o}, 32'd2);
        rst_i = 1'b1;
        #1;
        chk("mr_abandon", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0; ack_en = 1'b1;
        #1;
        chk("mr_vld", {31'd0, output_valid_o}, 32'd0);
        chk("mr_adr", wb_adr_o, 32'h100);
        wait_valid("mr_first", n);
        chk("mr_lat", n, 2); chk("mr_pc", pc_o, 32'h100); chk("mr_in", instr_o, memf(32'h100));
`endif

        // wrap-around instance
        chk("wrap_cnt", w_cnt, 3);
        chk("wrap_pc0", w_pc_log[0], 32'hFFFF_FFF8);
        chk("wrap_pc1", w_pc_log[1], 32'hFFFF_FFFC);
        chk("wrap_pc2", w_pc_log[2], 32'h0000_0000);
        chk("wrap_in2", w_in_log[2], memf(32'h0));
        chk("wrap_tie", {27'd0, w_we, w_sel}, 32'h0000_000F);
        chk("wrap_dat_o", w_dat_o, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
